// File: rtl/serial_accum_pkg.sv
// Shared types and constants for the bit-serial accumulator.
package serial_accum_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic full_add_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

endpackage

// File: rtl/serial_accum_carry_cell.sv
// JK carry flip-flop of the serial adder: J=a&b sets, K=~(a|b) resets, otherwise holds.
module carry_cell (
    input  logic clk,
    input  logic rst,
    input  logic sclr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic q
);

    logic j_s;
    logic k_s;
    logic q_d;
    logic q_q;

    // JK next-state with synchronous clear taking priority over the shift enable
    always_comb begin
        j_s = a & b;
        k_s = ~(a | b);
        q_d = q_q;
        if (sclr) begin
            q_d = 1'b0;
        end else if (en) begin
            q_d = (j_s & ~q_q) | (~k_s & q_q);
        end else begin
            q_d = q_q;
        end
    end

    // Carry register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/serial_accum.sv
// Bit-serial accumulator: shifts one operand bit pair per cycle through a JK carry
// cell, adding one WIDTH-bit addend per accepted start command.
module serial_accum
    import serial_accum_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 32'd1) ? $clog2(WIDTH) : 32'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 32'd1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] add_q;
    logic [WIDTH-1:0] add_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             ready_s;
    logic             clear_s;
    logic             accept_s;
    logic             shift_s;
    logic             carry_s;
    logic             sum_s;
    logic             busy_s;
    logic             done_s;

    // Command decode: clr wins over start, and both only count outside SHIFT
    always_comb begin
        ready_s  = (state_q == IDLE) || (state_q == DONE);
        clear_s  = ready_s && clr;
        accept_s = ready_s && !clr && start;
        shift_s  = (state_q == SHIFT);
        sum_s    = full_add_sum(acc_q[0], add_q[0], carry_s);
    end

    carry_cell u_carry (
        .clk  (clk),
        .rst  (rst),
        .sclr (clear_s | accept_s),
        .en   (shift_s),
        .a    (acc_q[0]),
        .b    (add_q[0]),
        .q    (carry_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from registered state only
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_q)
            SHIFT:   busy_s = 1'b1;
            DONE:    done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Datapath next-state: load on accept, rotate sum bits in while shifting
    always_comb begin
        acc_d = acc_q;
        add_d = add_q;
        cnt_d = cnt_q;
        if (clear_s) begin
            acc_d = '0;
        end else if (accept_s) begin
            add_d = din;
            cnt_d = '0;
        end else if (shift_s) begin
            acc_d = {sum_s, acc_q[WIDTH-1:1]};
            add_d = {1'b0, add_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
        end else begin
            acc_d = acc_q;
            add_d = add_q;
            cnt_d = cnt_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            add_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            add_q <= add_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign cout = carry_s;
    assign busy = busy_s;
    assign done = done_s;

endmodule
